// File: rtl/id_ex_register.sv
// id_ex_register: ID/EX pipeline register for the pipelined MIPS datapath.
// It captures the decoded control flags, operand data and register indices
// from ID and presents them to EX one cycle later. A branch-taken flush
// squashes the ID instruction by loading a bubble.
// Build option: define HAZARD_DETECT_EN to enable load-use hazard detection,
// the combinational stall output and the saturating stall counter. Without
// it, stall and stall_count are tied to 0, and software must schedule load
// delay slots.
//
// A bubble clears ex_valid, the eight control flags and ex_alu_op. The data
// and index fields still capture their ID values, so the datapath stays
// deterministic. Downstream logic gates on ex_valid.
module id_ex_register #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic                      id_reg_dst,
  input  logic                      id_alu_src,
  input  logic                      id_mem_to_reg,
  input  logic                      id_reg_write,
  input  logic                      id_mem_read,
  input  logic                      id_mem_write,
  input  logic                      id_branch_ne,
  input  logic                      id_branch_eq,
  input  logic [3:0]                id_alu_op,
  input  logic [DATA_WIDTH-1:0]     id_pc_plus4,
  input  logic [DATA_WIDTH-1:0]     id_read_data1,
  input  logic [DATA_WIDTH-1:0]     id_read_data2,
  input  logic [DATA_WIDTH-1:0]     id_imm_ext,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  output logic                      ex_valid,
  output logic                      ex_reg_dst,
  output logic                      ex_alu_src,
  output logic                      ex_mem_to_reg,
  output logic                      ex_reg_write,
  output logic                      ex_mem_read,
  output logic                      ex_mem_write,
  output logic                      ex_branch_ne,
  output logic                      ex_branch_eq,
  output logic [3:0]                ex_alu_op,
  output logic [DATA_WIDTH-1:0]     ex_pc_plus4,
  output logic [DATA_WIDTH-1:0]     ex_read_data1,
  output logic [DATA_WIDTH-1:0]     ex_read_data2,
  output logic [DATA_WIDTH-1:0]     ex_imm_ext,
  output logic [REG_ADDR_WIDTH-1:0] ex_rs,
  output logic [REG_ADDR_WIDTH-1:0] ex_rt,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic                      stall,
  output logic [CNT_WIDTH-1:0]      stall_count
);

  logic hazard;
  logic loadBubble;

`ifdef HAZARD_DETECT_EN
  logic usesRt;

  // An instruction reads rt when it is R-type (no immediate operand), a
  // store, or a branch compare.
  assign usesRt = !id_alu_src | id_mem_write | id_branch_eq | id_branch_ne;

  // Load-use hazard: the load in EX writes the register that ID reads. $zero
  // is exempt. A single bubble clears ex_mem_read, so the hazard resolves in
  // one cycle.
  assign hazard = id_valid & ex_valid & ex_mem_read & (ex_rt != '0) &
                  ((ex_rt == id_rs) | (usesRt & (ex_rt == id_rt)));
`else
  assign hazard = 1'b0;
`endif

  // A flush outranks a hazard. During reset no stall is requested.
  assign stall      = hazard & !flush & !reset;
  assign loadBubble = flush | hazard;

  // Pipeline register: reset clears everything. Otherwise the data and index
  // fields always load, and the control fields load as a bubble on flush or
  // hazard.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid      <= 1'b0;
      ex_reg_dst    <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_branch_ne  <= 1'b0;
      ex_branch_eq  <= 1'b0;
      ex_alu_op     <= 4'h0;
      ex_pc_plus4   <= '0;
      ex_read_data1 <= '0;
      ex_read_data2 <= '0;
      ex_imm_ext    <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_rd         <= '0;
    end else begin
      ex_pc_plus4   <= id_pc_plus4;
      ex_read_data1 <= id_read_data1;
      ex_read_data2 <= id_read_data2;
      ex_imm_ext    <= id_imm_ext;
      ex_rs         <= id_rs;
      ex_rt         <= id_rt;
      ex_rd         <= id_rd;
      if (loadBubble) begin
        ex_valid      <= 1'b0;
        ex_reg_dst    <= 1'b0;
        ex_alu_src    <= 1'b0;
        ex_mem_to_reg <= 1'b0;
        ex_reg_write  <= 1'b0;
        ex_mem_read   <= 1'b0;
        ex_mem_write  <= 1'b0;
        ex_branch_ne  <= 1'b0;
        ex_branch_eq  <= 1'b0;
        ex_alu_op     <= 4'h0;
      end else begin
        ex_valid      <= id_valid;
        ex_reg_dst    <= id_reg_dst;
        ex_alu_src    <= id_alu_src;
        ex_mem_to_reg <= id_mem_to_reg;
        ex_reg_write  <= id_reg_write;
        ex_mem_read   <= id_mem_read;
        ex_mem_write  <= id_mem_write;
        ex_branch_ne  <= id_branch_ne;
        ex_branch_eq  <= id_branch_eq;
        ex_alu_op     <= id_alu_op;
      end
    end
  end

`ifdef HAZARD_DETECT_EN
  logic [CNT_WIDTH-1:0] stallCnt;

  // Saturating stall-cycle counter. Only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      stallCnt <= '0;
    end else if (stall && (stallCnt != {CNT_WIDTH{1'b1}})) begin
      stallCnt <= stallCnt + 1'b1;
    end
  end

  assign stall_count = stallCnt;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_id_ex_register.sv
// tb_id_ex_register: directed scoreboard bench for id_ex_register.
// The driver applies one ID vector per cycle. For that cycle it queues the
// expected stall, and it queues the expected EX state after the next edge.
// Two monitors pop the queues and compare them against the DUT.
module tb_id_ex_register;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 2;

  // flags order: reg_dst, alu_src, mem_to_reg, reg_write, mem_read,
  // mem_write, branch_ne, branch_eq
  typedef struct packed {
    logic          valid;
    logic [7:0]    flags;
    logic [3:0]    alu_op;
    logic [DW-1:0] pc;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] imm;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
  } id_t;

  typedef struct packed {
    id_t           f;
    logic [CW-1:0] cnt;
  } ex_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  id_t  drv = '0;
  ex_t  act;

  logic          ex_valid, ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write;
  logic          ex_mem_read, ex_mem_write, ex_branch_ne, ex_branch_eq;
  logic [3:0]    ex_alu_op;
  logic [DW-1:0] ex_pc_plus4, ex_read_data1, ex_read_data2, ex_imm_ext;
  logic [AW-1:0] ex_rs, ex_rt, ex_rd;
  logic          stall;
  logic [CW-1:0] stall_count;

  ex_t  state_q[$];
  logic stall_q[$];
  int   total = 0;
  int   bad = 0;
  int   exp_cnt = 0;

  // Clock and reset
  always #5 clk = ~clk;

  id_ex_register #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .id_valid(drv.valid),
    .id_reg_dst(drv.flags[7]), .id_alu_src(drv.flags[6]),
    .id_mem_to_reg(drv.flags[5]), .id_reg_write(drv.flags[4]),
    .id_mem_read(drv.flags[3]), .id_mem_write(drv.flags[2]),
    .id_branch_ne(drv.flags[1]), .id_branch_eq(drv.flags[0]),
    .id_alu_op(drv.alu_op), .id_pc_plus4(drv.pc), .id_read_data1(drv.rd1),
    .id_read_data2(drv.rd2), .id_imm_ext(drv.imm), .id_rs(drv.rs),
    .id_rt(drv.rt), .id_rd(drv.rd),
    .ex_valid(ex_valid), .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch_ne(ex_branch_ne), .ex_branch_eq(ex_branch_eq),
    .ex_alu_op(ex_alu_op), .ex_pc_plus4(ex_pc_plus4),
    .ex_read_data1(ex_read_data1), .ex_read_data2(ex_read_data2),
    .ex_imm_ext(ex_imm_ext), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .stall(stall), .stall_count(stall_count)
  );

  always_comb begin
    act = '0;
    act.f.valid  = ex_valid;
    act.f.flags  = {ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write,
                    ex_mem_read, ex_mem_write, ex_branch_ne, ex_branch_eq};
    act.f.alu_op = ex_alu_op;
    act.f.pc     = ex_pc_plus4;
    act.f.rd1    = ex_read_data1;
    act.f.rd2    = ex_read_data2;
    act.f.imm    = ex_imm_ext;
    act.f.rs     = ex_rs;
    act.f.rt     = ex_rt;
    act.f.rd     = ex_rd;
    act.cnt      = stall_count;
  end

  function automatic id_t mk(input logic v, input logic [7:0] fl, input logic [3:0] op,
                             input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                             input logic [AW-1:0] rd, input logic [DW-1:0] imm);
    id_t r;
    r.valid = v; r.flags = fl; r.alu_op = op;
    r.pc = $urandom; r.rd1 = $urandom; r.rd2 = $urandom; r.imm = imm;
    r.rs = rs; r.rt = rt; r.rd = rd;
    return r;
  endfunction

  function automatic id_t rnd();
    id_t r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r;
  endfunction

  // Driver: one cycle of stimulus with hand-determined stall and bubble
  // outcomes (written for the build with hazard detection enabled).
  task automatic step(input id_t v, input logic rst, input logic fl,
                      input logic hz_stall, input logic hz_bubble);
    logic es, eb;
    ex_t  e;
`ifdef HAZARD_DETECT_EN
    es = hz_stall;
    eb = hz_bubble;
`else
    es = 1'b0;
    eb = fl;
    if (hz_stall && hz_bubble) es = 1'b0;
`endif
    @(posedge clk);
    #2;
    drv = v;
    reset = rst;
    flush = fl;
    stall_q.push_back(es);
    if (rst) begin
      e = '0;
      exp_cnt = 0;
    end else begin
      e.f = v;
      if (eb) begin
        e.f.valid = 1'b0;
        e.f.flags = 8'h00;
        e.f.alu_op = 4'h0;
      end
      if (es && exp_cnt < 3) exp_cnt++;
      e.cnt = exp_cnt[CW-1:0];
    end
    state_q.push_back(e);
  endtask

  // Monitor: combinational stall, sampled mid-cycle
  always @(negedge clk) begin
    if (stall_q.size() != 0) begin
      logic es;
      es = stall_q.pop_front();
      total++;
      if (stall !== es) begin
        bad++;
        $display("FAIL stall t=%0t got=%b exp=%b", $time, stall, es);
      end
    end
  end

  // Monitor: registered EX state, sampled just after the edge
  always @(posedge clk) begin
    #1;
    if (state_q.size() != 0) begin
      ex_t e;
      e = state_q.pop_front();
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL ex_state t=%0t got=%h exp=%h", $time, act, e);
      end
    end
  end

  localparam logic [7:0] F_ADDI = 8'b0101_0000;
  localparam logic [7:0] F_LW   = 8'b0111_1000;
  localparam logic [7:0] F_R    = 8'b1001_0000;
  localparam logic [7:0] F_SW   = 8'b0100_0100;
  localparam logic [7:0] F_BEQ  = 8'b0000_0001;

  initial begin
    id_t a;
    // Reset for two cycles with random ID inputs
    step(rnd(), 1'b1, 1'b0, 1'b0, 1'b0);
    step(rnd(), 1'b1, 1'b0, 1'b0, 1'b0);
    // ADDI pass-through
    step(mk(1'b1, F_ADDI, 4'h1, 5'd3, 5'd8, 5'd0, 32'h0000_0005), 1'b0, 1'b0, 1'b0, 1'b0);
    // lw rt=9, then R-type rs=9: one stall, bubble, then reload
    step(mk(1'b1, F_LW, 4'h0, 5'd2, 5'd9, 5'd0, 32'h4), 1'b0, 1'b0, 1'b0, 1'b0);
    a = mk(1'b1, F_R, 4'h2, 5'd9, 5'd10, 5'd11, 32'h0);
    step(a, 1'b0, 1'b0, 1'b1, 1'b1);
    step(a, 1'b0, 1'b0, 1'b0, 1'b0);
    // $zero exemption
    step(mk(1'b1, F_LW, 4'h0, 5'd2, 5'd0, 5'd0, 32'h8), 1'b0, 1'b0, 1'b0, 1'b0);
    step(mk(1'b1, F_R, 4'h2, 5'd0, 5'd0, 5'd12, 32'h0), 1'b0, 1'b0, 1'b0, 1'b0);
    // ADDI does not read rt
    step(mk(1'b1, F_LW, 4'h0, 5'd2, 5'd4, 5'd0, 32'hc), 1'b0, 1'b0, 1'b0, 1'b0);
    step(mk(1'b1, F_ADDI, 4'h1, 5'd2, 5'd4, 5'd0, 32'h7), 1'b0, 1'b0, 1'b0, 1'b0);
    // sw reads rt
    step(mk(1'b1, F_LW, 4'h0, 5'd2, 5'd5, 5'd0, 32'h10), 1'b0, 1'b0, 1'b0, 1'b0);
    a = mk(1'b1, F_SW, 4'h0, 5'd1, 5'd5, 5'd0, 32'h14);
    step(a, 1'b0, 1'b0, 1'b1, 1'b1);
    step(a, 1'b0, 1'b0, 1'b0, 1'b0);
    // beq reads rt
    step(mk(1'b1, F_LW, 4'h0, 5'd2, 5'd6, 5'd0, 32'h18), 1'b0, 1'b0, 1'b0, 1'b0);
    a = mk(1'b1, F_BEQ, 4'h3, 5'd1, 5'd6, 5'd0, 32'h20);
    step(a, 1'b0, 1'b0, 1'b1, 1'b1);
    step(a, 1'b0, 1'b0, 1'b0, 1'b0);
    // Flush beats hazard: no stall, bubble, counter unchanged
    step(mk(1'b1, F_LW, 4'h0, 5'd2, 5'd7, 5'd0, 32'h1c), 1'b0, 1'b0, 1'b0, 1'b0);
    a = mk(1'b1, F_R, 4'h2, 5'd7, 5'd1, 5'd13, 32'h0);
    step(a, 1'b0, 1'b1, 1'b0, 1'b1);
    step(a, 1'b0, 1'b0, 1'b0, 1'b0);
    // Invalid ID slot: no hazard, fields still copied with ex_valid=0
    step(mk(1'b1, F_LW, 4'h0, 5'd2, 5'd12, 5'd0, 32'h24), 1'b0, 1'b0, 1'b0, 1'b0);
    step(mk(1'b0, F_R, 4'h2, 5'd12, 5'd3, 5'd14, 32'h0), 1'b0, 1'b0, 1'b0, 1'b0);
    // Reset during a would-be stall
    step(mk(1'b1, F_LW, 4'h0, 5'd2, 5'd13, 5'd0, 32'h28), 1'b0, 1'b0, 1'b0, 1'b0);
    a = mk(1'b1, F_R, 4'h2, 5'd13, 5'd1, 5'd15, 32'h0);
    step(a, 1'b1, 1'b0, 1'b0, 1'b0);
    step(a, 1'b0, 1'b0, 1'b0, 1'b0);
    // Five stalls saturate the 2-bit counter at 3
    for (int i = 0; i < 5; i++) begin
      step(mk(1'b1, F_LW, 4'h0, 5'd2, 5'd9, 5'd0, 32'h30), 1'b0, 1'b0, 1'b0, 1'b0);
      a = mk(1'b1, F_R, 4'h2, 5'd9, 5'd10, 5'd11, 32'h0);
      step(a, 1'b0, 1'b0, 1'b1, 1'b1);
      step(a, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    // Let the monitors drain; undrained entries count as failures
    repeat (2) @(posedge clk);
    #3;
    total++;
    if (state_q.size() != 0 || stall_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d/%0d exp=0/0", state_q.size(), stall_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_register.md
# id_ex_register

ID/EX pipeline register for the pipelined MIPS datapath, downstream of the Control unit and register file. Each clock it captures the decoded control flags (RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, BranchNE, BranchEQ, ALUOp[3:0]) together with operand data and register indices, and presents them to the EX stage. It contains load-use hazard detection. On a hazard it inserts a bubble and asserts `stall` to freeze PC and IF/ID. It also accepts a branch-taken flush.

## Interface
- DATA_WIDTH, 32, width of PC+4, register read data and sign-extended immediate
- REG_ADDR_WIDTH, 5, width of rs/rt/rd indices
- CNT_WIDTH, 16, width of saturating stall-cycle counter
- clk  in  1  rising-edge clock, the only clock
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- flush  in  1  branch taken in EX; squash the ID instruction
- id_valid  in  1  ID slot holds a real instruction
- id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read, id_mem_write, id_branch_ne, id_branch_eq  in  1 each  Control flags
- id_alu_op  in  4  Control ALUOp
- id_pc_plus4, id_read_data1, id_read_data2, id_imm_ext  in  DATA_WIDTH  ID operands
- id_rs, id_rt, id_rd  in  REG_ADDR_WIDTH  ID register indices
- ex_* (same names, `ex_` prefix)  out  same widths  registered copies
- ex_valid  out  1  EX slot holds a real instruction
- stall  out  1  combinational; hold PC and IF/ID this cycle
- stall_count  out  CNT_WIDTH  saturating count of stall cycles

## Operation
- Define `uses_rt = !id_alu_src | id_mem_write | id_branch_eq | id_branch_ne`.
- Define `hazard = id_valid & ex_valid & ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (uses_rt & (ex_rt == id_rt)))`.
- `stall = hazard & !flush & !reset`.
- Update priority at each rising edge:
  - reset: all outputs go to 0. This covers every ex_* field, ex_valid and stall_count.
  - else flush: the register is loaded as a bubble.
  - else hazard: the register is loaded as a bubble.
  - else normal load: every ex_* field takes its id_* value, and ex_valid takes id_valid.
- A bubble means:
  - ex_valid = 0.
  - All eight control flags and ex_alu_op = 0.
  - Data and index fields (pc_plus4, read_data1/2, imm_ext, rs, rt, rd) still capture their id_* values.
- If id_valid = 0, the load still copies the id_* values. Downstream logic gates on ex_valid.
- stall_count increments by 1 on each edge where stall = 1. It saturates at 2^CNT_WIDTH−1 and clears only on reset.
- No state machine is needed. A load-use hazard resolves in exactly one cycle, because the bubble clears ex_mem_read.

## Timing
- Latency is 1 cycle from id_* to ex_*.
- stall is combinational from ex_* state and id_* inputs, and is valid in the same cycle.
- Upstream must hold id_* stable during a stall cycle. The instruction is then re-presented and loads on the following edge.
- flush and hazard in the same cycle: flush wins, stall = 0, and the counter does not increment.
- reset mid-stall: stall reads 0 during the reset cycle. All state is 0 after the edge.
- Two back-to-back lw instructions, where the second depends on the first: exactly one stall cycle.

## Configuration
- `HAZARD_DETECT_EN` defined: the hazard logic and stall_count are implemented as described above.
- `HAZARD_DETECT_EN` undefined:
  - hazard is tied to 0, stall is tied to 0, and stall_count is tied to 0 with no counter flops.
  - Only flush produces bubbles. Software must schedule load delay slots.

## Test plan
- Reset: assert reset for 2 cycles with random id_* inputs -> all ex_* = 0, ex_valid = 0, stall = 0, stall_count = 0.
- Pass-through: id_valid = 1, ADDI flags (alu_src = 1, reg_write = 1, alu_op = 4'h1), id_rt = 8, id_imm_ext = 32'h0000_0005 -> one cycle later ex_* match, ex_valid = 1.
- Load-use: EX holds lw (mem_read = 1, rt = 9); ID holds R-type with rs = 9 -> stall = 1 for one cycle, then ex_valid = 0 with zero flags, then the R-type loads, and stall_count = 1.
- rt = 0 exemption and ALUSrc: EX lw rt = 0 with ID rs = 0 -> no stall. EX lw rt = 4 with ID ADDI rt = 4, rs = 2 -> no stall.
- Flush priority: hazard condition true and flush = 1 in the same cycle -> stall = 0, bubble loaded, stall_count unchanged.
- Saturation: CNT_WIDTH = 2, force 5 stall cycles -> stall_count = 3. Rebuild without HAZARD_DETECT_EN and repeat the load-use stimulus -> stall = 0 and no bubble.
